// File: rtl/way_select_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : way_select_pipe_pkg
//  Description : Shared widths and helpers for the N-way tag compare / select
//                path. Provides default tag width, data width and way count.
//  Revision    : 1.0 - initial release
// ============================================================================
package way_select_pipe_pkg;

    localparam int c_def_tag_w  = 20;
    localparam int c_def_data_w = 32;
    localparam int c_def_ways   = 4;

    // Ceiling log2 with a floor of 1 so a way index always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : way_select_pipe_pkg
`default_nettype wire

// File: rtl/way_match.sv
`default_nettype none
// ============================================================================
//  Module      : way_match
//  Description : Combinational per-way tag compare with a lowest-index
//                priority encoder. Shared by the data and instruction caches.
//                Optional macro WAY_MULTIHIT_CHK_EN adds a multi-hit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module way_match
  import way_select_pipe_pkg::*;
#(
  parameter int TAG  = c_def_tag_w,
  parameter int WAYS = c_def_ways,
  parameter int WAYW = clog2(WAYS)
) (
  input  logic [TAG-1:0]      req_tag,
  input  logic [WAYS*TAG-1:0] way_tags,
  input  logic [WAYS-1:0]     way_valid,
  output logic [WAYS-1:0]     match,
  output logic                hit,
`ifdef WAY_MULTIHIT_CHK_EN
  output logic                multi_hit,
`endif
  output logic [WAYW-1:0]     hit_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign match[gi] = way_valid[gi] && (way_tags[gi*TAG +: TAG] == req_tag);
    end
  endgenerate

  assign hit = |match;

  // Lowest matching way wins: scan downward so the smallest index is written last.
  always_comb begin
    hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = WAYW'(i);
    end
  end

`ifdef WAY_MULTIHIT_CHK_EN
  logic w_seen;

  // Flag a second match once any earlier way has already matched.
  always_comb begin
    w_seen    = 1'b0;
    multi_hit = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (match[i]) begin
        if (w_seen) multi_hit = 1'b1;
        w_seen = 1'b1;
      end
    end
  end
`endif

endmodule : way_match
`default_nettype wire

// File: rtl/way_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : way_select_pipe
//  Description : N-way tag compare, hit-way encode and data select with one
//                valid/ready registered stage and a round-robin refill victim
//                pointer. Optional macro WAY_MULTIHIT_CHK_EN adds MultiHit.
//  Revision    : 1.0 - initial release
// ============================================================================
module way_select_pipe
  import way_select_pipe_pkg::*;
#(
  parameter int TAG       = c_def_tag_w,
  parameter int DATAWIDTH = c_def_data_w,
  parameter int WAYS      = c_def_ways
) (
  input  logic                      Clk,
  input  logic                      Reset_N,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [TAG-1:0]            ReqTag,
  input  logic [WAYS*TAG-1:0]       WayTags,
  input  logic [WAYS-1:0]           WayValid,
  input  logic [WAYS*DATAWIDTH-1:0] WayData,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      Hit,
  output logic [clog2(WAYS)-1:0]    HitWay,
  output logic [DATAWIDTH-1:0]      OutData,
`ifdef WAY_MULTIHIT_CHK_EN
  output logic                      MultiHit,
`endif
  output logic [clog2(WAYS)-1:0]    VictimWay
);

  localparam int WAYW = clog2(WAYS);

  logic [WAYS-1:0]      w_match;
  logic                 w_hit;
  logic [WAYW-1:0]      w_hit_idx;
  logic [DATAWIDTH-1:0] w_sel_data;
  logic                 w_free_found;
  logic [WAYW-1:0]      w_free_idx;
  logic [WAYW-1:0]      w_victim;
  logic                 w_accept;
  logic                 w_rr_step;
  logic [WAYW-1:0]      w_rr_next;

  logic                 r_valid;
  logic                 r_hit;
  logic [WAYW-1:0]      r_hit_way;
  logic [DATAWIDTH-1:0] r_data;
  logic [WAYW-1:0]      r_victim;
  logic [WAYW-1:0]      r_rr;

`ifdef WAY_MULTIHIT_CHK_EN
  logic w_multi;
  logic r_multi;
`endif

  way_match #(
    .TAG  (TAG),
    .WAYS (WAYS),
    .WAYW (WAYW)
  ) u_way_match (
    .req_tag   (ReqTag),
    .way_tags  (WayTags),
    .way_valid (WayValid),
    .match     (w_match),
    .hit       (w_hit),
`ifdef WAY_MULTIHIT_CHK_EN
    .multi_hit (w_multi),
`endif
    .hit_idx   (w_hit_idx)
  );

  // A held result blocks new work until the consumer takes it.
  assign InReady  = !r_valid || OutReady;
  assign w_accept = InValid && InReady;

  // Data of the lowest matching way; zero when nothing matches.
  always_comb begin
    w_sel_data = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_sel_data = WayData[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Prefer refilling the lowest invalid way; fall back to round-robin only when the set is full.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!WayValid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = WAYW'(i);
      end
    end
  end

  assign w_victim  = w_hit ? '0 : (w_free_found ? w_free_idx : r_rr);
  assign w_rr_step = w_accept && !w_hit && !w_free_found;
  assign w_rr_next = (r_rr == WAYW'(WAYS - 1)) ? '0 : r_rr + 1'b1;

  // Result register: load on accept, drop valid on drain, otherwise hold.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_valid   <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_way <= '0;
      r_data    <= '0;
      r_victim  <= '0;
      r_rr      <= '0;
`ifdef WAY_MULTIHIT_CHK_EN
      r_multi   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_hit     <= w_hit;
        r_hit_way <= w_hit_idx;
        r_data    <= w_sel_data;
        r_victim  <= w_victim;
`ifdef WAY_MULTIHIT_CHK_EN
        r_multi   <= w_multi;
`endif
      end else if (OutReady) begin
        r_valid   <= 1'b0;
      end
      if (w_rr_step) r_rr <= w_rr_next;
    end
  end

  assign OutValid  = r_valid;
  assign Hit       = r_hit;
  assign HitWay    = r_hit_way;
  assign OutData   = r_data;
  assign VictimWay = r_victim;
`ifdef WAY_MULTIHIT_CHK_EN
  assign MultiHit  = r_multi;
`endif

endmodule : way_select_pipe
`default_nettype wire
